verdict_tracker: RTL
====================

# verdict_tracker

Tracks reorder tags and filter verdicts for `circular_buffer`. It hands out reorder tags to packets entering the buffer and collects accept/reject verdicts from `NUM_CORES` filter cores through a round-robin arbiter. It drives `packet_status` for whatever `reorder_tag_out` the buffer presents. It sits between the ingress stage, the filter cores and the buffer's status/tag ports.

## Interface
- `TAG_WIDTH`, 6, width of a reorder tag.
- `CIRCULAR_BUFFER_SIZE`, 50, number of slots. Must match `circular_buffer` and be ≤ 2^`TAG_WIDTH`.
- `NUM_CORES`, 4, number of verdict requesters.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `alloc_req`  in  1  ingress requests a tag for a new packet.
- `alloc_gnt`  out  1  tag granted this cycle.
- `alloc_tag`  out  `TAG_WIDTH`  tag being offered; valid whenever `alloc_gnt` is high.
- `verdict_valid`  in  `NUM_CORES`  per-core verdict request.
- `verdict_tag`  in  `NUM_CORES*TAG_WIDTH`  per-core tag; core i uses bits `[i*TAG_WIDTH +: TAG_WIDTH]`.
- `verdict_accept`  in  `NUM_CORES`  1 = accept, 0 = reject.
- `verdict_ready`  out  `NUM_CORES`  one-hot grant.
- `reorder_tag_out`  in  `TAG_WIDTH`  slot currently at the head of `circular_buffer`.
- `packet_status`  out  2  verdict for that slot: 00 pending, 01 rejected, 11 accepted.
- `occupancy`  out  `TAG_WIDTH+1`  number of allocated slots.
- `err_verdict`  out  1  sticky flag for an illegal verdict.

## Operation
- Each slot is in one of four states: FREE, WAIT, ACC, REJ.
  - `packet_status` reads 11 for ACC, 01 for REJ, and 00 for FREE and WAIT.
- **Allocation**
  - `alloc_tag` is the registered head pointer.
  - `alloc_gnt = alloc_req && occupancy < CIRCULAR_BUFFER_SIZE`.
  - On a grant: slot[head] goes to WAIT, and head increments, wrapping from `CIRCULAR_BUFFER_SIZE-1` to 0.
- **Verdict arbitration**
  - A round-robin arbiter picks one valid requester per cycle, starting from the core after the last one granted.
  - `verdict_ready` is combinational.
  - On the granting edge the slot goes to ACC or REJ.
  - The verdict is ignored and `err_verdict` is set if the slot is not in WAIT, or if the tag is ≥ `CIRCULAR_BUFFER_SIZE`.
  - A requester holds `verdict_valid` and its tag until it sees ready.
- **Release**
  - `prev_tag` is a registered copy of `reorder_tag_out`.
  - When `reorder_tag_out != prev_tag`, slot[prev_tag] goes to FREE and occupancy decrements.
- **Simultaneous events**
  - Allocation and release in the same cycle leave occupancy unchanged.
  - A verdict aimed at the slot being released that cycle is an error: release wins.
  - A slot allocated and released in the same cycle cannot occur, because the buffer never advances past an unallocated slot.

## Timing
- `alloc_gnt`, `verdict_ready` and `packet_status` are combinational, from registered state and current inputs.
- A verdict or allocation becomes visible on `packet_status` and `occupancy` one cycle after its handshake.
- A release becomes visible one cycle after `reorder_tag_out` changes.
- While `rst` is low, the following are forced at the next edge:
  - every slot to FREE;
  - head, `prev_tag`, `occupancy`, the arbiter pointer and `err_verdict` to 0.
- Output values during reset:
  - `alloc_gnt` and `verdict_ready` are 0 whenever `rst` is low.
  - `packet_status` is 00 from the first edge after `rst` goes low.
- Reset mid-packet discards all tags. The ingress stage is responsible for restarting.
- Full: `alloc_gnt` is held at 0 while `occupancy == CIRCULAR_BUFFER_SIZE`, and returns in the cycle after a release.

## Configuration
- `VERDICT_TRACKER_STATS_EN`
  - **Defined:** adds 32-bit saturating counters `stat_accepted`, `stat_rejected` and `stat_errors` as outputs. They increment on each granted verdict of that kind (errors count ignored verdicts) and clear on reset.
  - **Undefined:** these ports and the counter logic do not exist.

## Structure
- Shared package `bpf_reorder_pkg` holds:
  - the status codes `PENDING`, `REJECTED`, `ACCEPTED`;
  - the slot-state typedef (FREE/WAIT/ACC/REJ);
  - the function mapping slot state to `packet_status`.
- The one natural sub-module is `rr_arbiter`, parameterised by `NUM_CORES`: request vector in, one-hot grant out, pointer updates on grant.

## Test plan
- **Fill to full:** after reset, `CIRCULAR_BUFFER_SIZE`=3, hold `alloc_req` high → tags 0, 1, 2 granted on consecutive cycles, then `alloc_gnt`=0 with `occupancy`=3.
- **Arbitration:** cores 0, 1 and 3 all request on tags 0, 1 and 2 with accept = 1, 0, 1 → grants in order core 0, core 1, core 3. With `reorder_tag_out`=1, `packet_status`=01.
- **Release and wrap:** `reorder_tag_out` goes 0→1 → slot 0 is FREE next cycle and `occupancy` drops by one. The next grant gives tag 0 (wrap-around).
- **Illegal verdicts:** a verdict on a FREE slot, a repeated verdict on an ACC slot, and a verdict on tag 5 with size 3 → each is ignored, `err_verdict`=1, and slot state is unchanged.
- **Simultaneous allocate and release:** alloc and release in the same cycle → `occupancy` unchanged.
- **Reset mid-operation:** `rst` low for one cycle while 2 slots are ACC → all status 00, `occupancy` 0, next `alloc_tag`=0.

Source files
------------

// File: rtl/bpf_reorder_pkg.sv
// Shared reorder/verdict types: packet status codes, per-slot state and the state->status mapping.
// Pure declarations, no timing or flow control of its own.
package bpf_reorder_pkg;

  localparam logic [1:0] PENDING  = 2'b00;
  localparam logic [1:0] REJECTED = 2'b01;
  localparam logic [1:0] ACCEPTED = 2'b11;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    WAIT = 2'd1,
    ACC  = 2'd2,
    REJ  = 2'd3
  } slot_state_e;

  function automatic logic [1:0] slot_status(input slot_state_e s);
    case (s)
      ACC:     return ACCEPTED;
      REJ:     return REJECTED;
      default: return PENDING;
    endcase
  endfunction

endpackage

// File: rtl/verdict_tracker_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting after the last winner.
// Zero latency; the pointer only advances on a grant, so held requests are served fairly.
module rr_arbiter #(
  parameter int NUM_CORES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CORES-1:0] req,
  output logic [NUM_CORES-1:0] gnt
);

  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  int            best;
  int            win;

  // Winner is the requester at the smallest cyclic distance from the pointer.
  always_comb begin
    best  = NUM_CORES;
    win   = 0;
    gnt   = '0;
    ptr_d = ptr_q;
    for (int j = 0; j < NUM_CORES; j++) begin
      if (req[j] && (((j + NUM_CORES - int'(ptr_q)) % NUM_CORES) < best)) begin
        best = (j + NUM_CORES - int'(ptr_q)) % NUM_CORES;
        win  = j;
      end
    end
    for (int j = 0; j < NUM_CORES; j++) begin
      gnt[j] = (best < NUM_CORES) && (win == j);
    end
    if (best < NUM_CORES) begin
      ptr_d = PW'((win + 1) % NUM_CORES);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/verdict_tracker.sv
// Reorder-tag allocator and verdict collector for circular_buffer; state visible one cycle after each handshake.
// Grants/ready are combinational, alloc stalls while full; optional counters under VERDICT_TRACKER_STATS_EN.
module verdict_tracker
  import bpf_reorder_pkg::*;
#(
  parameter int TAG_WIDTH            = 6,
  parameter int CIRCULAR_BUFFER_SIZE = 50,
  parameter int NUM_CORES            = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           alloc_req,
  output logic                           alloc_gnt,
  output logic [TAG_WIDTH-1:0]           alloc_tag,
  input  logic [NUM_CORES-1:0]           verdict_valid,
  input  logic [NUM_CORES*TAG_WIDTH-1:0] verdict_tag,
  input  logic [NUM_CORES-1:0]           verdict_accept,
  output logic [NUM_CORES-1:0]           verdict_ready,
  input  logic [TAG_WIDTH-1:0]           reorder_tag_out,
  output logic [1:0]                     packet_status,
  output logic [TAG_WIDTH:0]             occupancy,
`ifdef VERDICT_TRACKER_STATS_EN
  output logic [31:0]                    stat_accepted,
  output logic [31:0]                    stat_rejected,
  output logic [31:0]                    stat_errors,
`endif
  output logic                           err_verdict
);

  // Slot array spans the whole tag space so any tag indexes it safely.
  localparam int                   NUM_SLOTS = 2 ** TAG_WIDTH;
  localparam logic [TAG_WIDTH:0]   SIZE_W    = (TAG_WIDTH+1)'(CIRCULAR_BUFFER_SIZE);
  localparam logic [TAG_WIDTH-1:0] LAST_TAG  = TAG_WIDTH'(CIRCULAR_BUFFER_SIZE - 1);

  slot_state_e          slot_q [NUM_SLOTS];
  slot_state_e          slot_d [NUM_SLOTS];
  logic [TAG_WIDTH-1:0] head_q, head_d;
  logic [TAG_WIDTH-1:0] prev_tag_q, prev_tag_d;
  logic [TAG_WIDTH:0]   occ_q, occ_d;
  logic                 err_q, err_d;

  logic                 release_evt;
  logic                 vld_any;
  logic                 verdict_bad;
  logic                 sel_acc;
  logic [TAG_WIDTH-1:0] sel_tag;
  logic [NUM_CORES-1:0] arb_req;

  assign arb_req     = rst ? verdict_valid : '0;
  assign alloc_gnt   = rst && alloc_req && (occ_q < SIZE_W);
  assign alloc_tag   = head_q;
  assign occupancy   = occ_q;
  assign err_verdict = err_q;
  assign release_evt = (reorder_tag_out != prev_tag_q);

  assign packet_status = ({1'b0, reorder_tag_out} < SIZE_W) ? slot_status(slot_q[reorder_tag_out])
                                                            : PENDING;

  rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (arb_req),
    .gnt (verdict_ready)
  );

  always_comb begin
    sel_tag = '0;
    sel_acc = 1'b0;
    for (int j = 0; j < NUM_CORES; j++) begin
      if (verdict_ready[j]) begin
        sel_tag = verdict_tag[j*TAG_WIDTH +: TAG_WIDTH];
        sel_acc = verdict_accept[j];
      end
    end
    vld_any     = |verdict_ready;
    // A verdict racing the release of its own slot loses.
    verdict_bad = ({1'b0, sel_tag} >= SIZE_W) || (slot_q[sel_tag] != WAIT) ||
                  (release_evt && (sel_tag == prev_tag_q));
  end

  always_comb begin
    slot_d     = slot_q;
    head_d     = head_q;
    prev_tag_d = reorder_tag_out;
    err_d      = err_q;
    occ_d      = occ_q + (TAG_WIDTH+1)'(alloc_gnt) - (TAG_WIDTH+1)'(release_evt);
    if (release_evt) begin
      slot_d[prev_tag_q] = FREE;
    end
    if (vld_any) begin
      if (verdict_bad) begin
        err_d = 1'b1;
      end else begin
        slot_d[sel_tag] = sel_acc ? ACC : REJ;
      end
    end
    if (alloc_gnt) begin
      slot_d[head_q] = WAIT;
      head_d         = (head_q == LAST_TAG) ? '0 : head_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= FREE;
      end
      head_q     <= '0;
      prev_tag_q <= '0;
      occ_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      head_q     <= head_d;
      prev_tag_q <= prev_tag_d;
      occ_q      <= occ_d;
      err_q      <= err_d;
    end
  end

`ifdef VERDICT_TRACKER_STATS_EN
  logic [31:0] stat_acc_q, stat_acc_d;
  logic [31:0] stat_rej_q, stat_rej_d;
  logic [31:0] stat_err_q, stat_err_d;

  always_comb begin
    stat_acc_d = stat_acc_q;
    stat_rej_d = stat_rej_q;
    stat_err_d = stat_err_q;
    if (vld_any && verdict_bad && (stat_err_q != '1)) begin
      stat_err_d = stat_err_q + 32'd1;
    end
    if (vld_any && !verdict_bad && sel_acc && (stat_acc_q != '1)) begin
      stat_acc_d = stat_acc_q + 32'd1;
    end
    if (vld_any && !verdict_bad && !sel_acc && (stat_rej_q != '1)) begin
      stat_rej_d = stat_rej_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_acc_q <= '0;
      stat_rej_q <= '0;
      stat_err_q <= '0;
    end else begin
      stat_acc_q <= stat_acc_d;
      stat_rej_q <= stat_rej_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign stat_accepted = stat_acc_q;
  assign stat_rejected = stat_rej_q;
  assign stat_errors   = stat_err_q;
`endif

endmodule
